blowfish_engine: RTL and testbench



---
 rtl/blowfish_pkg.sv | 11 +
 rtl/blowfish_round_ctrl.sv | 44 ++++
 rtl/blowfish_engine.sv | 111 +++++++++++
 tb/tb_blowfish_engine.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blowfish_pkg.sv
// blowfish_pkg: FSM states, S-box offsets and the Blowfish F-function shared by the engine and its bench
package blowfish_pkg;
    typedef enum logic [2:0] {IDLE, XP, SB, FR, OUT} state_t;
    localparam int S0_OFF = 0;
    localparam int S1_OFF = 256;
    localparam int S2_OFF = 512;
    localparam int S3_OFF = 768;
    function automatic logic [31:0] bf_f(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        return ((a + b) ^ c) + d;
    endfunction
endpackage

// File: rtl/blowfish_round_ctrl.sv
// blowfish_round_ctrl: round counter and P-array address generation (first, next, final pair) for encrypt/decrypt; load/step/decrypt in, last and addresses out
module blowfish_round_ctrl #(
    parameter int ADDR_W = 12,
    parameter int ROUNDS = 16,
    parameter int P_ARRAY_OFFSET = 4000
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              load,
    input  logic              step,
    input  logic              decrypt,
    output logic              last,
    output logic [ADDR_W-1:0] first_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic [ADDR_W-1:0] fin_addr_a,
    output logic [ADDR_W-1:0] fin_addr_b
);
    logic [3:0] cnt;
    logic       dec_q;

    function automatic logic [ADDR_W-1:0] p_addr(input logic dec, input int k);
        return ADDR_W'(P_ARRAY_OFFSET + (dec ? ROUNDS + 1 - k : k));
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            cnt   <= '0;
            dec_q <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            dec_q <= decrypt;
        end else if (step) begin
            cnt   <= cnt + 4'd1;
        end
    end

    always_comb begin
        last       = cnt == 4'(ROUNDS - 1);
        first_addr = p_addr(decrypt, 0);
        next_addr  = p_addr(dec_q, int'(cnt) + 1);
        fin_addr_a = p_addr(dec_q, ROUNDS + 1);
        fin_addr_b = p_addr(dec_q, ROUNDS);
    end
endmodule

// File: rtl/blowfish_engine.sv
// blowfish_engine: iterative Blowfish block engine; start/decrypt/L/R in, ready/resultL/resultR/done out, addr/cs/we/oe out and data in for read-only SRAM ports A and B
module blowfish_engine
    import blowfish_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int ROUNDS = 16,
    parameter int P_ARRAY_OFFSET = 4000,
    parameter int S_BASE = 0
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              start,
    input  logic              decrypt,
    input  logic [31:0]       L,
    input  logic [31:0]       R,
    output logic              ready,
    output logic [31:0]       resultL,
    output logic [31:0]       resultR,
    output logic              done,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [31:0]       data_a,
    input  logic [31:0]       data_b,
    output logic              cs_a_l,
    output logic              cs_b_l,
    output logic              we_a_l,
    output logic              we_b_l,
    output logic              oe_a_l,
    output logic              oe_b_l
);
    state_t            state;
    logic [31:0]       l_q, r_q, f_q, xl;
    logic              accept, last;
    logic [ADDR_W-1:0] first_addr, next_addr, fin_addr_a, fin_addr_b;

    blowfish_round_ctrl #(
        .ADDR_W(ADDR_W),
        .ROUNDS(ROUNDS),
        .P_ARRAY_OFFSET(P_ARRAY_OFFSET)
    ) u_ctrl (
        .clk(clk),
        .reset_l(reset_l),
        .load(accept),
        .step(state == FR && !last),
        .decrypt(decrypt),
        .last(last),
        .first_addr(first_addr),
        .next_addr(next_addr),
        .fin_addr_a(fin_addr_a),
        .fin_addr_b(fin_addr_b)
    );

    assign ready  = state == IDLE;
    assign we_a_l = 1'b1;
    assign we_b_l = 1'b1;
    assign oe_a_l = 1'b0;
    assign oe_b_l = 1'b0;

    always_comb begin
        accept = state == IDLE && start;
        xl     = l_q ^ data_a;
        cs_a_l = !(accept || state == XP || state == SB || state == FR);
        cs_b_l = !(state == XP || state == SB || (state == FR && last));
        addr_a = state == XP ? ADDR_W'(S_BASE + S0_OFF + int'(xl[31:24])) :
                 state == SB ? ADDR_W'(S_BASE + S2_OFF + int'(l_q[15:8])) :
                 state == FR ? (last ? fin_addr_a : next_addr) : first_addr;
        addr_b = state == XP ? ADDR_W'(S_BASE + S1_OFF + int'(xl[23:16])) :
                 state == SB ? ADDR_W'(S_BASE + S3_OFF + int'(l_q[7:0])) : fin_addr_b;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state   <= IDLE;
            done    <= 1'b0;
            resultL <= '0;
            resultR <= '0;
            l_q     <= '0;
            r_q     <= '0;
            f_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    l_q   <= L;
                    r_q   <= R;
                    state <= XP;
                end
                XP: begin
                    l_q   <= xl;
                    state <= SB;
                end
                SB: begin
                    f_q   <= data_a + data_b;
                    state <= FR;
                end
                FR: begin
                    l_q   <= r_q ^ bf_f(f_q, 32'd0, data_a, data_b);
                    r_q   <= l_q;
                    state <= last ? OUT : XP;
                end
                OUT: begin
                    resultL <= r_q ^ data_a;
                    resultR <= l_q ^ data_b;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blowfish_engine.sv
// tb_blowfish_engine: randomized self-checking bench for a 16-round and a 2-round engine sharing one SRAM image
module tb_blowfish_engine;
    import blowfish_pkg::*;

    localparam int LAT16 = 3 * 16 + 2;
    localparam int LAT2  = 3 * 2 + 2;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    logic [1:0] start = '0, decrypt = '0;
    logic [1:0] ready, done, cs_a_l, cs_b_l, we_a_l, we_b_l, oe_a_l, oe_b_l;
    logic [1:0][31:0] L = '0, R = '0, res_l, res_r;
    logic [1:0][11:0] addr_a, addr_b;
    logic [31:0] rd_a [2];
    logic [31:0] rd_b [2];
    logic [31:0] mem [4096];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // unselected reads return garbage so the engine cannot rely on stale data
    always @(posedge clk)
        for (int g = 0; g < 2; g++) begin
            rd_a[g] <= !cs_a_l[g] ? mem[addr_a[g]] : $urandom;
            rd_b[g] <= !cs_b_l[g] ? mem[addr_b[g]] : $urandom;
        end

    blowfish_engine #(.ROUNDS(16)) u_dut16 (
        .clk(clk), .reset_l(reset_l), .start(start[0]), .decrypt(decrypt[0]),
        .L(L[0]), .R(R[0]), .ready(ready[0]), .resultL(res_l[0]), .resultR(res_r[0]),
        .done(done[0]), .addr_a(addr_a[0]), .addr_b(addr_b[0]),
        .data_a(rd_a[0]), .data_b(rd_b[0]), .cs_a_l(cs_a_l[0]), .cs_b_l(cs_b_l[0]),
        .we_a_l(we_a_l[0]), .we_b_l(we_b_l[0]), .oe_a_l(oe_a_l[0]), .oe_b_l(oe_b_l[0])
    );

    blowfish_engine #(.ROUNDS(2)) u_dut2 (
        .clk(clk), .reset_l(reset_l), .start(start[1]), .decrypt(decrypt[1]),
        .L(L[1]), .R(R[1]), .ready(ready[1]), .resultL(res_l[1]), .resultR(res_r[1]),
        .done(done[1]), .addr_a(addr_a[1]), .addr_b(addr_b[1]),
        .data_a(rd_a[1]), .data_b(rd_b[1]), .cs_a_l(cs_a_l[1]), .cs_b_l(cs_b_l[1]),
        .we_a_l(we_a_l[1]), .we_b_l(we_b_l[1]), .oe_a_l(oe_a_l[1]), .oe_b_l(oe_b_l[1])
    );

    function automatic logic [31:0] pw(input int i);
        return mem[12'(4000 + i)];
    endfunction

    function automatic logic [31:0] f_of(input logic [31:0] x);
        return bf_f(mem[{4'd0, x[31:24]}], mem[{4'd1, x[23:16]}], mem[{4'd2, x[15:8]}], mem[{4'd3, x[7:0]}]);
    endfunction

    // textbook Blowfish: xor P, xor F into the other half, swap; undo last swap; whiten
    function automatic logic [63:0] model(input logic [31:0] l0, input logic [31:0] r0, input logic dec, input int rounds);
        logic [31:0] l, r, t;
        l = l0;
        r = r0;
        for (int i = 0; i < rounds; i++) begin
            l = l ^ pw(dec ? rounds + 1 - i : i);
            r = r ^ f_of(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ pw(dec ? 1 : rounds);
        l = l ^ pw(dec ? 0 : rounds + 1);
        return {l, r};
    endfunction

    task automatic fill(input bit rnd);
        for (int i = 0; i < 4096; i++) mem[i] = rnd ? $urandom : 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int sel);
        int n = 0;
        while (!ready[sel] && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (ready[sel] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait inst%0d: ready=%b required 1 within 200 cycles", sel, ready[sel]);
        end
    endtask

    // issues one block and returns at the done cycle; counts chip selects in the issuing window
    task automatic run(input int sel, input logic [31:0] l, input logic [31:0] r, input logic dec,
                       output logic [63:0] res, output int lat, output int na, output int nb);
        if (!ready[sel]) wait_ready(sel);
        start[sel] = 1'b1;
        decrypt[sel] = dec;
        L[sel] = l;
        R[sel] = r;
        #1;
        na = int'(!cs_a_l[sel]);
        nb = int'(!cs_b_l[sel]);
        lat = 0;
        while (lat < 400) begin
            @(posedge clk);
            #1;
            start[sel] = 1'b0;
            #1;
            lat++;
            if (done[sel]) break;
            na += int'(!cs_a_l[sel]);
            nb += int'(!cs_b_l[sel]);
        end
        res = {res_l[sel], res_r[sel]};
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({ready[s], done[s], res_l[s], res_r[s], cs_a_l[s], cs_b_l[s]} !== {1'b1, 1'b0, 64'd0, 2'b11}) begin
                errors++;
                $display("FAIL reset inst%0d: ready=%b done=%b res=%h cs=%b%b required 1 0 0 11",
                         s, ready[s], done[s], {res_l[s], res_r[s]}, cs_a_l[s], cs_b_l[s]);
            end
            checks++;
            if ({we_a_l[s], we_b_l[s], oe_a_l[s], oe_b_l[s]} !== 4'b1100) begin
                errors++;
                $display("FAIL tie inst%0d: we/oe=%b required 1100", s, {we_a_l[s], we_b_l[s], oe_a_l[s], oe_b_l[s]});
            end
        end
        reset_l = 1'b1;
        tick();
    endtask

    task automatic test_zero_sram();
        logic [63:0] res;
        int lat, na, nb;
        fill(1'b0);
        run(0, 32'h01234567, 32'h89ABCDEF, 1'b0, res, lat, na, nb);
        checks++;
        if (res !== 64'h89ABCDEF_01234567) begin
            errors++;
            $display("FAIL zero_sram: result=%h required 89abcdef01234567", res);
        end
        checks++;
        if ({lat, na, nb} !== {LAT16, 3 * 16 + 1, 2 * 16 + 1}) begin
            errors++;
            $display("FAIL zero_timing: lat=%0d csA=%0d csB=%0d required %0d %0d %0d", lat, na, nb, LAT16, 49, 33);
        end
    endtask

    task automatic test_p0();
        logic [63:0] res;
        int lat, na, nb;
        fill(1'b0);
        mem[4000] = 32'h11111111;
        run(0, 32'd0, 32'd0, 1'b0, res, lat, na, nb);
        checks++;
        if (res !== 64'h00000000_11111111) begin
            errors++;
            $display("FAIL p0_encrypt: result=%h required 0000000011111111", res);
        end
        run(0, 32'd0, 32'h11111111, 1'b1, res, lat, na, nb);
        checks++;
        if (res !== 64'd0) begin
            errors++;
            $display("FAIL p0_decrypt: result=%h required 0", res);
        end
    endtask

    task automatic test_random16();
        logic [63:0] x, e, res;
        int lat, na, nb;
        fill(1'b1);
        for (int v = 0; v < 20; v++) begin
            x = {$urandom, $urandom};
            e = model(x[63:32], x[31:0], 1'b0, 16);
            run(0, x[63:32], x[31:0], 1'b0, res, lat, na, nb);
            checks++;
            if (res !== e || lat != LAT16) begin
                errors++;
                $display("FAIL rand16_enc v%0d: result=%h lat=%0d required %h %0d", v, res, lat, e, LAT16);
            end
            run(0, res[63:32], res[31:0], 1'b1, res, lat, na, nb);
            checks++;
            if (res !== x) begin
                errors++;
                $display("FAIL rand16_dec v%0d: result=%h required %h", v, res, x);
            end
            x = {$urandom, $urandom};
            e = model(x[63:32], x[31:0], 1'b1, 16);
            run(0, x[63:32], x[31:0], 1'b1, res, lat, na, nb);
            checks++;
            if (res !== e) begin
                errors++;
                $display("FAIL rand16_dec_model v%0d: result=%h required %h", v, res, e);
            end
        end
    endtask

    task automatic test_handshake();
        logic [63:0] e, prev;
        logic exp_r, exp_d;
        int dones = 0;
        wait_ready(0);
        tick();
        e = model(32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 16);
        start[0] = 1'b1;
        decrypt[0] = 1'b0;
        L[0] = 32'hCAFEF00D;
        R[0] = 32'h0BADBEEF;
        prev = {res_l[0], res_r[0]};
        for (int c = 0; c < 200; c++) begin
            #1;
            exp_r = c % LAT16 == 0;
            exp_d = exp_r && c > 0;
            checks++;
            if ({ready[0], done[0]} !== {exp_r, exp_d}) begin
                errors++;
                $display("FAIL handshake c%0d: ready=%b done=%b required %b %b", c, ready[0], done[0], exp_r, exp_d);
            end
            checks++;
            if (done[0] ? {res_l[0], res_r[0]} !== e : {res_l[0], res_r[0]} !== prev) begin
                errors++;
                $display("FAIL handshake_result c%0d: result=%h required %h", c, {res_l[0], res_r[0]}, done[0] ? e : prev);
            end
            dones += int'(done[0]);
            prev = {res_l[0], res_r[0]};
            tick();
        end
        start[0] = 1'b0;
        checks++;
        if (dones != 3) begin
            errors++;
            $display("FAIL handshake_count: dones=%0d required 3", dones);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat, na, nb, seen = 0;
        wait_ready(0);
        fill(1'b0);
        start[0] = 1'b1;
        decrypt[0] = 1'b0;
        L[0] = 32'h01234567;
        R[0] = 32'h89ABCDEF;
        for (int c = 0; c < 20; c++) begin
            tick();
            start[0] = 1'b0;
        end
        reset_l = 1'b0;
        tick();
        checks++;
        if ({ready[0], done[0], res_l[0], res_r[0]} !== {1'b1, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reset_mid: ready=%b done=%b result=%h required 1 0 0", ready[0], done[0], {res_l[0], res_r[0]});
        end
        reset_l = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            seen += int'(done[0]);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_abort: dones=%0d required 0", seen);
        end
        run(0, 32'h01234567, 32'h89ABCDEF, 1'b0, res, lat, na, nb);
        checks++;
        if (res !== 64'h89ABCDEF_01234567 || lat != LAT16) begin
            errors++;
            $display("FAIL reset_rerun: result=%h lat=%0d required 89abcdef01234567 %0d", res, lat, LAT16);
        end
    endtask

    task automatic test_rounds2();
        logic [63:0] x, e, res;
        int lat, na, nb;
        for (int v = 0; v < 1000; v++) begin
            if (v % 100 == 0) fill(1'b1);
            x = {$urandom, $urandom};
            e = model(x[63:32], x[31:0], 1'b0, 2);
            run(1, x[63:32], x[31:0], 1'b0, res, lat, na, nb);
            checks++;
            if (res !== e) begin
                errors++;
                $display("FAIL r2_enc v%0d: result=%h required %h", v, res, e);
            end
            checks++;
            if ({lat, na, nb} !== {LAT2, 7, 5}) begin
                errors++;
                $display("FAIL r2_timing v%0d: lat=%0d csA=%0d csB=%0d required %0d 7 5", v, lat, na, nb, LAT2);
            end
            run(1, res[63:32], res[31:0], 1'b1, res, lat, na, nb);
            checks++;
            if (res !== x || lat != LAT2) begin
                errors++;
                $display("FAIL r2_identity v%0d: result=%h lat=%0d required %h %0d", v, res, lat, x, LAT2);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_zero_sram();
        test_p0();
        test_random16();
        test_handshake();
        test_reset_mid();
        test_rounds2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
